// File: rtl/wrap_event_monitor_pkg.sv
// ---------------------------------------------------------------------------
// wrap_event_monitor_pkg
// Shared definitions for the wrap event monitor:
//   - default widths of the upstream counter and the epoch (wrap) counter
//   - CNT_MAX, the all-ones value of the default counter width
//   - the interrupt FSM state type
// ---------------------------------------------------------------------------
package wrap_event_monitor_pkg;

  localparam int DEFAULT_CNT_W   = 4;
  localparam int DEFAULT_EPOCH_W = 8;

  localparam logic [DEFAULT_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_PENDING  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/wrap_event_monitor_if.sv
// ---------------------------------------------------------------------------
// wrap_event_monitor_if
// Bundles the monitor's data, control and status signals.
//   Inputs to the monitor : count_in, ovf_in, ack, clr_epoch
//   Outputs of the monitor: wrap_pulse, ovf_rise, epoch_count, epoch_sat,
//                           ext_count, irq, irq_missed
// Modports:
//   master - the side that drives the counter stream and control (upstream/TB)
//   slave  - the monitor itself
// ---------------------------------------------------------------------------
interface wrap_event_monitor_if
  import wrap_event_monitor_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int EPOCH_W = DEFAULT_EPOCH_W
);

  logic [CNT_W-1:0]         count_in;
  logic                     ovf_in;
  logic                     ack;
  logic                     clr_epoch;

  logic                     wrap_pulse;
  logic                     ovf_rise;
  logic [EPOCH_W-1:0]       epoch_count;
  logic                     epoch_sat;
  logic [EPOCH_W+CNT_W-1:0] ext_count;
  logic                     irq;
  logic                     irq_missed;

  modport master (
    output count_in, ovf_in, ack, clr_epoch,
    input  wrap_pulse, ovf_rise, epoch_count, epoch_sat, ext_count, irq, irq_missed
  );

  modport slave (
    input  count_in, ovf_in, ack, clr_epoch,
    output wrap_pulse, ovf_rise, epoch_count, epoch_sat, ext_count, irq, irq_missed
  );

endinterface

// File: rtl/wrap_event_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// wrap_event_monitor_sat_counter
// Saturating up-counter with a sticky saturation flag.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   inc         - count one event
//   clr         - clear count and flag; wins over a simultaneous inc
//   count_o     - registered count
//   count_next_o- value the count takes at the next edge (for coherent
//                 snapshots that combine the count with other live data)
//   sat_o       - sticky: an increment arrived while the count was all-ones
// ---------------------------------------------------------------------------
module wrap_event_monitor_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_next_o,
  output logic         sat_o
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  // At all-ones the count holds and the event is only recorded in the flag.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      if (count_q == '1) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign sat_o        = sat_q;

endmodule

// File: rtl/wrap_event_monitor.sv
// ---------------------------------------------------------------------------
// wrap_event_monitor
// Watches an upstream up-counter and its sticky overflow flag. Detects each
// wrap from all-ones to zero, counts wraps in a saturating epoch counter,
// publishes a coherent {epoch, count} extended value and raises a level
// interrupt every THRESH wraps with a request/acknowledge handshake.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   mon        - wrap_event_monitor_if.slave:
//                in : count_in, ovf_in, ack, clr_epoch
//                out: wrap_pulse, ovf_rise, epoch_count, epoch_sat,
//                     ext_count, irq, irq_missed
// ---------------------------------------------------------------------------
module wrap_event_monitor
  import wrap_event_monitor_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int EPOCH_W = DEFAULT_EPOCH_W,
  parameter int THRESH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  wrap_event_monitor_if.slave mon
);

  // The package constant covers the default width; other widths build their own.
  localparam logic [CNT_W-1:0] CNT_ONES =
    (CNT_W == DEFAULT_CNT_W) ? CNT_W'(CNT_MAX) : {CNT_W{1'b1}};
  localparam logic [EPOCH_W-1:0] ACC_LAST = EPOCH_W'(THRESH - 1);

  logic [CNT_W-1:0]         prev_count_q, prev_count_d;
  logic                     prev_ovf_q, prev_ovf_d;
  logic                     wrap_pulse_q, wrap_pulse_d;
  logic                     ovf_rise_q, ovf_rise_d;
  logic [EPOCH_W+CNT_W-1:0] ext_count_q, ext_count_d;
  logic                     irq_q, irq_d;
  logic                     irq_missed_q, irq_missed_d;
  logic [EPOCH_W-1:0]       wrap_acc_q, wrap_acc_d;
  irq_state_e               state_q, state_d;

  logic                     wrap;
  logic                     thresh_hit;
  logic [EPOCH_W-1:0]       epoch_q;
  logic [EPOCH_W-1:0]       epoch_d;
  logic                     epoch_sat_q;

  // A hold at all-ones or a jump straight to zero is not a wrap; only the
  // exact all-ones -> zero step between consecutive samples counts.
  assign wrap       = (prev_count_q == CNT_ONES) && (mon.count_in == '0);
  assign thresh_hit = wrap && (wrap_acc_q == ACC_LAST);

  wrap_event_monitor_sat_counter #(
    .W (EPOCH_W)
  ) u_epoch (
    .clk          (clk),
    .reset        (reset),
    .inc          (wrap),
    .clr          (mon.clr_epoch),
    .count_o      (epoch_q),
    .count_next_o (epoch_d),
    .sat_o        (epoch_sat_q)
  );

  // Sample history, edge pulses and the extended count. Using the epoch's
  // next value keeps the snapshot coherent across a wrap ({E,F} -> {E+1,0}).
  always_comb begin
    prev_count_d = mon.count_in;
    prev_ovf_d   = mon.ovf_in;
    wrap_pulse_d = wrap;
    ovf_rise_d   = mon.ovf_in && !prev_ovf_q;
    ext_count_d  = {epoch_d, mon.count_in};
  end

  // Interrupt FSM. A threshold wrap always (re)arms the request; if the
  // previous request was still unacknowledged it is recorded as missed.
  // clr_epoch clears the missed flag only and wins over a new miss.
  always_comb begin
    state_d      = state_q;
    wrap_acc_d   = wrap_acc_q;
    irq_missed_d = irq_missed_q;
    case (state_q)
      ST_COUNTING: begin
        if (thresh_hit) begin
          state_d    = ST_PENDING;
          wrap_acc_d = '0;
        end else if (wrap) begin
          wrap_acc_d = wrap_acc_q + EPOCH_W'(1);
        end
      end
      ST_PENDING: begin
        if (thresh_hit) begin
          wrap_acc_d = '0;
          if (!mon.ack) begin
            irq_missed_d = 1'b1;
          end
        end else begin
          if (wrap) begin
            wrap_acc_d = wrap_acc_q + EPOCH_W'(1);
          end
          if (mon.ack) begin
            state_d = ST_COUNTING;
          end
        end
      end
      default: state_d = ST_COUNTING;
    endcase
    if (mon.clr_epoch) begin
      irq_missed_d = 1'b0;
    end
    irq_d = (state_d == ST_PENDING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count_q <= '0;
      prev_ovf_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
      ovf_rise_q   <= 1'b0;
      ext_count_q  <= '0;
      irq_q        <= 1'b0;
      irq_missed_q <= 1'b0;
      wrap_acc_q   <= '0;
      state_q      <= ST_COUNTING;
    end else begin
      prev_count_q <= prev_count_d;
      prev_ovf_q   <= prev_ovf_d;
      wrap_pulse_q <= wrap_pulse_d;
      ovf_rise_q   <= ovf_rise_d;
      ext_count_q  <= ext_count_d;
      irq_q        <= irq_d;
      irq_missed_q <= irq_missed_d;
      wrap_acc_q   <= wrap_acc_d;
      state_q      <= state_d;
    end
  end

  assign mon.wrap_pulse  = wrap_pulse_q;
  assign mon.ovf_rise    = ovf_rise_q;
  assign mon.epoch_count = epoch_q;
  assign mon.epoch_sat   = epoch_sat_q;
  assign mon.ext_count   = ext_count_q;
  assign mon.irq         = irq_q;
  assign mon.irq_missed  = irq_missed_q;

endmodule

// File: tb/tb_wrap_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_wrap_event_monitor
// Two monitors share one stimulus stream:
//   dut_a: CNT_W=4, EPOCH_W=8, THRESH=4
//   dut_b: CNT_W=4, EPOCH_W=2, THRESH=1 (fast saturation, irq on every wrap)
// A behavioural model tracks wraps, epochs and outstanding requests with plain
// integers; every cycle both DUTs are compared against it. Directed sequences
// add literal expectations, then a randomized stream runs.
// ---------------------------------------------------------------------------
module tb_wrap_event_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] tb_count;
  logic       tb_ovf;
  logic       tb_ack;
  logic       tb_clr;

  int checks   = 0;
  int failures = 0;

  wrap_event_monitor_if #(.CNT_W(4), .EPOCH_W(8)) bus_a ();
  wrap_event_monitor_if #(.CNT_W(4), .EPOCH_W(2)) bus_b ();

  assign bus_a.count_in  = tb_count;
  assign bus_a.ovf_in    = tb_ovf;
  assign bus_a.ack       = tb_ack;
  assign bus_a.clr_epoch = tb_clr;
  assign bus_b.count_in  = tb_count;
  assign bus_b.ovf_in    = tb_ovf;
  assign bus_b.ack       = tb_ack;
  assign bus_b.clr_epoch = tb_clr;

  wrap_event_monitor #(.CNT_W(4), .EPOCH_W(8), .THRESH(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .mon   (bus_a)
  );

  wrap_event_monitor #(.CNT_W(4), .EPOCH_W(2), .THRESH(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .mon   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state, index 0 = dut_a, 1 = dut_b
  int epoch_max [2] = '{255, 3};
  int thresh    [2] = '{4, 1};
  int m_prev    [2] = '{0, 0};
  int m_prevovf [2] = '{0, 0};
  int m_wrap    [2] = '{0, 0};
  int m_rise    [2] = '{0, 0};
  int m_epoch   [2] = '{0, 0};
  int m_sat     [2] = '{0, 0};
  int m_ext     [2] = '{0, 0};
  int m_pend    [2] = '{0, 0};
  int m_missed  [2] = '{0, 0};
  int m_wraps   [2] = '{0, 0};
  bit armed = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // One clock edge of the model: wraps toward the next request are counted
  // since the last threshold; a threshold wrap while a request is still
  // outstanding and not acknowledged that same edge counts as missed.
  task automatic modelStep(input int k, input int r, input int c, input int o,
                           input int a, input int cl);
    int w;
    if (r != 0) begin
      m_prev[k] = 0; m_prevovf[k] = 0; m_wrap[k] = 0; m_rise[k] = 0;
      m_epoch[k] = 0; m_sat[k] = 0; m_ext[k] = 0; m_pend[k] = 0;
      m_missed[k] = 0; m_wraps[k] = 0;
    end else begin
      w = (m_prev[k] == 15 && c == 0) ? 1 : 0;
      m_wrap[k] = w;
      m_rise[k] = (o != 0 && m_prevovf[k] == 0) ? 1 : 0;
      if (cl != 0) begin
        m_epoch[k] = 0;
        m_sat[k]   = 0;
      end else if (w != 0) begin
        if (m_epoch[k] == epoch_max[k]) m_sat[k] = 1;
        else m_epoch[k] = m_epoch[k] + 1;
      end
      m_ext[k] = m_epoch[k] * 16 + c;
      if (w != 0 && m_wraps[k] + 1 == thresh[k]) begin
        if (m_pend[k] != 0 && a == 0) m_missed[k] = 1;
        m_pend[k]  = 1;
        m_wraps[k] = 0;
      end else begin
        if (w != 0) m_wraps[k] = m_wraps[k] + 1;
        if (m_pend[k] != 0 && a != 0) m_pend[k] = 0;
      end
      if (cl != 0) m_missed[k] = 0;
      m_prev[k]    = c;
      m_prevovf[k] = o;
    end
  endtask

  // Per-cycle compare: inputs are captured at the edge, the model advances,
  // and both DUTs are checked a little after the edge.
  always @(posedge clk) begin
    int s_r, s_c, s_o, s_a, s_cl;
    s_r  = int'(reset);
    s_c  = int'(tb_count);
    s_o  = int'(tb_ovf);
    s_a  = int'(tb_ack);
    s_cl = int'(tb_clr);
    #1;
    modelStep(0, s_r, s_c, s_o, s_a, s_cl);
    modelStep(1, s_r, s_c, s_o, s_a, s_cl);
    if (s_r != 0) armed = 1'b1;
    if (armed) begin
      checkOutput("a.wrap_pulse",  int'(bus_a.wrap_pulse),  m_wrap[0]);
      checkOutput("a.ovf_rise",    int'(bus_a.ovf_rise),    m_rise[0]);
      checkOutput("a.epoch_count", int'(bus_a.epoch_count), m_epoch[0]);
      checkOutput("a.epoch_sat",   int'(bus_a.epoch_sat),   m_sat[0]);
      checkOutput("a.ext_count",   int'(bus_a.ext_count),   m_ext[0]);
      checkOutput("a.irq",         int'(bus_a.irq),         m_pend[0]);
      checkOutput("a.irq_missed",  int'(bus_a.irq_missed),  m_missed[0]);
      checkOutput("b.wrap_pulse",  int'(bus_b.wrap_pulse),  m_wrap[1]);
      checkOutput("b.ovf_rise",    int'(bus_b.ovf_rise),    m_rise[1]);
      checkOutput("b.epoch_count", int'(bus_b.epoch_count), m_epoch[1]);
      checkOutput("b.epoch_sat",   int'(bus_b.epoch_sat),   m_sat[1]);
      checkOutput("b.ext_count",   int'(bus_b.ext_count),   m_ext[1]);
      checkOutput("b.irq",         int'(bus_b.irq),         m_pend[1]);
      checkOutput("b.irq_missed",  int'(bus_b.irq_missed),  m_missed[1]);
    end
  end

  // Drive one cycle of inputs at the falling edge and return just after the
  // following rising edge, once the per-cycle compare has run.
  task automatic applyStimulus(input logic r, input logic [3:0] c, input logic o,
                               input logic a, input logic cl);
    @(negedge clk);
    reset    = r;
    tb_count = c;
    tb_ovf   = o;
    tb_ack   = a;
    tb_clr   = cl;
    @(posedge clk);
    #2;
  endtask

  task automatic doWrap(input logic ack_on_wrap);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, ack_on_wrap, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] cnt;
    logic       ovf;
    reset = 1'b1; tb_count = 4'h0; tb_ovf = 1'b0; tb_ack = 1'b0; tb_clr = 1'b0;
    $display("[TB] start");

    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.ext_a", int'(bus_a.ext_count), 0);
    checkOutput("reset.irq_a", int'(bus_a.irq), 0);

    // First full count 0..F then 0
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("pre_wrap.ext_a", int'(bus_a.ext_count), 'h00F);
    checkOutput("pre_wrap.wrap_a", int'(bus_a.wrap_pulse), 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap1.wrap_a",  int'(bus_a.wrap_pulse), 1);
    checkOutput("wrap1.epoch_a", int'(bus_a.epoch_count), 1);
    checkOutput("wrap1.ext_a",   int'(bus_a.ext_count), 'h010);
    checkOutput("wrap1.model_ext_a", m_ext[0], 'h010);
    checkOutput("wrap1.irq_a",   int'(bus_a.irq), 0);
    checkOutput("wrap1.irq_b",   int'(bus_b.irq), 1);
    checkOutput("wrap1.ext_b",   int'(bus_b.ext_count), 'h10);

    // Wraps 2..4 without ack: request rises after the 4th
    for (int i = 0; i < 3; i++) doWrap(1'b0);
    checkOutput("wrap4.irq_a", int'(bus_a.irq), 1);
    checkOutput("wrap4.model_irq_a", m_pend[0], 1);
    applyStimulus(1'b0, 4'h1, 1'b0, 1'b1, 1'b0);
    checkOutput("ack.irq_a", int'(bus_a.irq), 0);

    // Eight more wraps with no ack: second request is missed
    for (int i = 0; i < 8; i++) doWrap(1'b0);
    checkOutput("wrap8.irq_a",    int'(bus_a.irq), 1);
    checkOutput("wrap8.missed_a", int'(bus_a.irq_missed), 1);
    for (int i = 0; i < 3; i++) doWrap(1'b0);
    doWrap(1'b1);
    checkOutput("wrap12_ack.irq_a",    int'(bus_a.irq), 1);
    checkOutput("wrap12_ack.missed_a", int'(bus_a.irq_missed), 1);
    checkOutput("sat.epoch_b", int'(bus_b.epoch_count), 3);
    checkOutput("sat.sat_b",   int'(bus_b.epoch_sat), 1);
    applyStimulus(1'b0, 4'h1, 1'b0, 1'b0, 1'b1);
    checkOutput("clr.epoch_a",  int'(bus_a.epoch_count), 0);
    checkOutput("clr.missed_a", int'(bus_a.irq_missed), 0);
    checkOutput("clr.irq_a",    int'(bus_a.irq), 1);

    // Clear on a wrap edge: clear wins for the epoch, the wrap still pulses
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_wrap.epoch_b", int'(bus_b.epoch_count), 0);
    checkOutput("clr_wrap.sat_b",   int'(bus_b.epoch_sat), 0);
    checkOutput("clr_wrap.wrap_b",  int'(bus_b.wrap_pulse), 1);

    // Hold at all-ones, then zero: exactly one wrap
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
      checkOutput("hold.wrap_a", int'(bus_a.wrap_pulse), 0);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_end.wrap_a", int'(bus_a.wrap_pulse), 1);

    // Jump 7 -> 0 is not a wrap
    applyStimulus(1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("jump.wrap_a", int'(bus_a.wrap_pulse), 0);

    // Overflow flag rising and held: one pulse
    applyStimulus(1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf1.rise_a", int'(bus_a.ovf_rise), 1);
    applyStimulus(1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf2.rise_a", int'(bus_a.ovf_rise), 0);
    applyStimulus(1'b0, 4'h3, 1'b0, 1'b0, 1'b0);

    // Reset on a would-be wrap edge discards it
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_wrap.wrap_a", int'(bus_a.wrap_pulse), 0);
    checkOutput("rst_wrap.irq_a",  int'(bus_a.irq), 0);
    checkOutput("rst_wrap.ext_a",  int'(bus_a.ext_count), 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst.wrap_a", int'(bus_a.wrap_pulse), 0);

    // Randomized stream: mostly counting up, with holds, jumps, acks,
    // clears, overflow toggles and occasional resets
    cnt = 4'h0;
    ovf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel < 12) cnt = cnt + 4'h1;
      else if (sel < 14) cnt = cnt;
      else cnt = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ovf = ~ovf;
      applyStimulus(($urandom_range(0, 499) == 0),
                    cnt, ovf,
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 59) == 0));
    end

    applyStimulus(1'b0, cnt, ovf, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
